// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: owns the board and alternates the human and
// engine turns. It also validates moves, detects win/draw and hands a timed-out
// human turn to the engine.
module ttt_turn_controller #(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter int unsigned CNT_W        = 26,
  parameter bit          HUMAN_FIRST  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  input  logic        eng_valid,
  input  logic [3:0]  eng_cell,
  output logic        eng_req,
  output logic [1:0]  eng_player,
  output logic [17:0] board,
  output logic [1:0]  cur_player,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        illegal_move,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUMAN   = 3'd1,
    ENG_REQ = 3'd2,
    CHECK   = 3'd3,
    WIN     = 3'd4,
    DRAW    = 3'd5
  } state_t;

  localparam logic [1:0]       P_HUMAN  = 2'b01;
  localparam logic [1:0]       P_ENGINE = 2'b10;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TURN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [17:0]      board_q, board_d;
  logic [1:0]       cur_player_q, cur_player_d;
  logic [1:0]       eng_player_q, eng_player_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             eng_req_q, eng_req_d;

  logic             human_legal;
  logic             eng_legal;
  logic [1:0]       line_win;
  logic             board_full;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = '0;
    for (int unsigned i = 0; i < 9; i++)
      if (idx == 4'(i)) v = b[2*i +: 2];
    return v;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] p);
    logic [17:0] r;
    r = b;
    for (int unsigned i = 0; i < 9; i++)
      if (idx == 4'(i)) r[2*i +: 2] = p;
    return r;
  endfunction

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return (a != 2'b00 && a == b && a == c) ? a : 2'b00;
  endfunction

  // Only the player who just moved can complete a line, so the first hit is the winner.
  function automatic logic [1:0] win_of(input logic [17:0] b);
    logic [1:0] c [9];
    logic [1:0] w;
    for (int unsigned i = 0; i < 9; i++) c[i] = b[2*i +: 2];
    w = line3(c[0], c[1], c[2]);
    if (w == 2'b00) w = line3(c[3], c[4], c[5]);
    if (w == 2'b00) w = line3(c[6], c[7], c[8]);
    if (w == 2'b00) w = line3(c[0], c[3], c[6]);
    if (w == 2'b00) w = line3(c[1], c[4], c[7]);
    if (w == 2'b00) w = line3(c[2], c[5], c[8]);
    if (w == 2'b00) w = line3(c[0], c[4], c[8]);
    if (w == 2'b00) w = line3(c[2], c[4], c[6]);
    return w;
  endfunction

  function automatic logic full_of(input logic [17:0] b);
    logic f;
    f = 1'b1;
    for (int unsigned i = 0; i < 9; i++)
      if (b[2*i +: 2] == 2'b00) f = 1'b0;
    return f;
  endfunction

  assign human_legal = (move_cell <= 4'd8) && (cell_at(board_q, move_cell) == 2'b00);
  assign eng_legal   = (eng_cell  <= 4'd8) && (cell_at(board_q, eng_cell)  == 2'b00);
  assign line_win    = win_of(board_q);
  assign board_full  = full_of(board_q);

  // Next-state, board update and strobe generation; start overrides every state.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    cur_player_d = cur_player_q;
    eng_player_d = eng_player_q;
    winner_d     = winner_q;
    timer_d      = timer_q;
    illegal_d    = 1'b0;
    timeout_d    = 1'b0;

    if (start) begin
      board_d  = '0;
      winner_d = '0;
      timer_d  = '0;
      if (HUMAN_FIRST) begin
        state_d      = HUMAN;
        cur_player_d = P_HUMAN;
        eng_player_d = 2'b00;
      end else begin
        state_d      = ENG_REQ;
        cur_player_d = P_ENGINE;
        eng_player_d = P_ENGINE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          board_d = '0;
        end
        HUMAN: begin
          timer_d = timer_q + 1'b1;
          if (move_valid) begin
            if (human_legal) begin
              board_d = set_cell(board_q, move_cell, P_HUMAN);
              timer_d = '0;
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (timer_q >= TMO_LAST) begin
            // >= so an illegal move on the expiry cycle only defers the timeout by one cycle
            timeout_d    = 1'b1;
            timer_d      = '0;
            state_d      = ENG_REQ;
            eng_player_d = P_HUMAN;
          end
        end
        ENG_REQ: begin
          if (eng_valid) begin
            if (eng_legal) begin
              board_d = set_cell(board_q, eng_cell, eng_player_q);
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_win != 2'b00) begin
            state_d      = WIN;
            winner_d     = line_win;
            cur_player_d = 2'b00;
          end else if (board_full) begin
            state_d      = DRAW;
            cur_player_d = 2'b00;
          end else if (cur_player_q == P_HUMAN) begin
            state_d      = ENG_REQ;
            cur_player_d = P_ENGINE;
            eng_player_d = P_ENGINE;
          end else begin
            state_d      = HUMAN;
            cur_player_d = P_HUMAN;
            timer_d      = '0;
          end
        end
        WIN, DRAW: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    eng_req_d = (state_d == ENG_REQ);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      board_q      <= '0;
      cur_player_q <= '0;
      eng_player_q <= '0;
      winner_q     <= '0;
      timer_q      <= '0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      eng_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      cur_player_q <= cur_player_d;
      eng_player_q <= eng_player_d;
      winner_q     <= winner_d;
      timer_q      <= timer_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      eng_req_q    <= eng_req_d;
    end
  end

  assign eng_req      = eng_req_q;
  assign eng_player   = eng_player_q;
  assign board        = board_q;
  assign cur_player   = cur_player_q;
  assign state        = state_q;
  assign winner       = winner_q;
  assign game_over    = (state_q == WIN) || (state_q == DRAW);
  assign illegal_move = illegal_q;
  assign timeout_flag = timeout_q;

endmodule
